// File: rtl/vpu_issue.sv
// vpu_issue: instruction fetch/decode/issue sequencer for the SIMD vector unit.
// It fetches 64-bit instructions from a synchronous BRAM, decodes them into the
// vector unit's field ports, pulses o_vpu_start and holds every field until
// i_vpu_done, then steps the PC. It stops on HALT (111) or an illegal type
// (100/101/110).
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_run, i_start_pc       start pulse and first PC (ignored while busy)
//   o_busy, o_halted        executing / program ended
//   o_err, o_err_pc         illegal type seen and its PC
//   o_imem_addr, o_imem_en  BRAM read port, i_imem_dout read data
//   o_vpu_start             one-cycle start pulse, i_vpu_done completion pulse
//   o_vpu_type .. o_scalar_b decoded fields, stable from DECODE to done
//   o_perf_cycles/instrs    only when VPU_ISSUE_PERF_EN is defined
//
// Optional feature macro: VPU_ISSUE_PERF_EN (busy-cycle and instruction counters).
module vpu_issue #(
    parameter int PC_W     = 10,
    parameter int INSTR_W  = 64,
    parameter int IMEM_LAT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic [PC_W-1:0]    i_start_pc,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_err,
    output logic [PC_W-1:0]    o_err_pc,
    output logic [PC_W-1:0]    o_imem_addr,
    output logic               o_imem_en,
    input  logic [INSTR_W-1:0] i_imem_dout,
    output logic               o_vpu_start,
    output logic [2:0]         o_vpu_type,
    output logic [9:0]         o_opcode,
    output logic [12:0]        o_addr_a,
    output logic [12:0]        o_addr_b,
    output logic [12:0]        o_addr_out,
    output logic [12:0]        o_addr_const,
    output logic [2:0]         o_vreg_dst,
    output logic [2:0]         o_vreg_a,
    output logic [2:0]         o_vreg_b,
    output logic [2:0]         o_vpu_opcode,
    output logic               o_scalar_b,
    input  logic               i_vpu_done
`ifdef VPU_ISSUE_PERF_EN
    ,
    output logic [31:0]        o_perf_cycles,
    output logic [31:0]        o_perf_instrs
`endif
);

    generate
        if (INSTR_W != 64) begin : g_bad_instr_w
            $error("vpu_issue: INSTR_W must be 64");
        end
        if (IMEM_LAT < 1) begin : g_bad_lat
            $error("vpu_issue: IMEM_LAT must be >= 1");
        end
    endgenerate

    // FWAIT counter: counts 1..IMEM_LAT-1, DECODE follows the last count.
    localparam int CNT_W = (IMEM_LAT > 2) ? $clog2(IMEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(IMEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_ISSUE, S_WAIT_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_pc;
    logic [2:0]       w_type;
    logic             w_accept;

    assign w_type   = i_imem_dout[63:61];
    assign w_accept = (r_state == S_IDLE) && i_run;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_imem_en   = 1'b0;
        o_imem_addr = '0;
        o_vpu_start = 1'b0;
        case (r_state)
            S_IDLE:      if (i_run) w_next = S_FETCH;
            S_FETCH: begin
                o_imem_en   = 1'b1;
                o_imem_addr = r_pc;
                w_next      = (IMEM_LAT == 1) ? S_DECODE : S_FWAIT;
            end
            S_FWAIT:     if (r_cnt == LAT_M1) w_next = S_DECODE;
            // type[2]==0 covers SCALAR/VLOAD/VSTORE/VCOMPUTE; all others end the run
            S_DECODE:    w_next = w_type[2] ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                o_vpu_start = 1'b1;
                w_next      = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (i_vpu_done) w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_pc         <= '0;
            o_busy       <= 1'b0;
            o_halted     <= 1'b0;
            o_err        <= 1'b0;
            o_err_pc     <= '0;
            o_vpu_type   <= '0;
            o_opcode     <= '0;
            o_addr_a     <= '0;
            o_addr_b     <= '0;
            o_addr_out   <= '0;
            o_addr_const <= '0;
            o_vreg_dst   <= '0;
            o_vreg_a     <= '0;
            o_vreg_b     <= '0;
            o_vpu_opcode <= '0;
            o_scalar_b   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_pc     <= i_start_pc;
                    o_busy   <= 1'b1;
                    o_halted <= 1'b0;
                    o_err    <= 1'b0;
                    o_err_pc <= '0;
                end
                S_FETCH: r_cnt <= CNT_W'(1);
                S_FWAIT: r_cnt <= r_cnt + 1'b1;
                S_DECODE: begin
                    if (!w_type[2]) begin
                        // Fields change only here, so they hold through WAIT_DONE and IDLE.
                        o_vpu_type <= w_type;
                        if (w_type == 3'b000) begin
                            o_opcode     <= i_imem_dout[60:51];
                            o_addr_a     <= i_imem_dout[50:38];
                            o_addr_b     <= i_imem_dout[37:25];
                            o_addr_out   <= i_imem_dout[24:12];
                            o_addr_const <= {1'b0, i_imem_dout[11:0]};
                            o_vreg_dst   <= '0;
                            o_vreg_a     <= '0;
                            o_vreg_b     <= '0;
                            o_vpu_opcode <= '0;
                            o_scalar_b   <= 1'b0;
                        end else begin
                            o_opcode     <= '0;
                            o_addr_a     <= i_imem_dout[47:35];
                            o_addr_b     <= '0;
                            o_addr_out   <= '0;
                            o_addr_const <= '0;
                            o_vreg_dst   <= i_imem_dout[60:58];
                            o_vreg_a     <= i_imem_dout[57:55];
                            o_vreg_b     <= i_imem_dout[54:52];
                            o_vpu_opcode <= i_imem_dout[51:49];
                            o_scalar_b   <= i_imem_dout[48];
                        end
                    end else begin
                        o_busy   <= 1'b0;
                        o_halted <= 1'b1;
                        if (w_type != 3'b111) begin
                            o_err    <= 1'b1;
                            o_err_pc <= r_pc;
                        end
                    end
                end
                S_WAIT_DONE: if (i_vpu_done) r_pc <= r_pc + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef VPU_ISSUE_PERF_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_perf_cycles <= '0;
            o_perf_instrs <= '0;
        end else if (w_accept) begin
            o_perf_cycles <= '0;
            o_perf_instrs <= '0;
        end else begin
            if (o_busy && (o_perf_cycles != '1))
                o_perf_cycles <= o_perf_cycles + 32'd1;
            if ((r_state == S_WAIT_DONE) && i_vpu_done && (o_perf_instrs != '1))
                o_perf_instrs <= o_perf_instrs + 32'd1;
        end
    end
`endif

endmodule

// File: doc/vpu_issue.md
Name: vpu_issue

Overview:
- Instruction fetch/decode/issue sequencer directly upstream of the SIMD vector unit.
- Fetches 64-bit VPU instructions from a synchronous instruction BRAM and decodes them into the vector unit's field ports.
- Pulses the vector unit's start, holds all fields stable until it reports done, then advances the PC.
- Runs a program from a host-supplied start PC until a HALT or an illegal instruction.

Parameters:
PC_W, 10, instruction memory address width (PC wraps modulo 2^PC_W)
INSTR_W, 64, instruction word width (fixed format, must be 64)
IMEM_LAT, 2, instruction BRAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
run  in  1  start pulse; ignored while busy
start_pc  in  PC_W  first instruction address, sampled with run
busy  out  1  program executing
halted  out  1  program ended (HALT or error); held until next accepted run
err  out  1  illegal vpu_type decoded; held until next accepted run
err_pc  out  PC_W  PC of the illegal instruction
imem_addr  out  PC_W  instruction BRAM address
imem_en  out  1  instruction BRAM read enable
imem_dout  in  INSTR_W  instruction BRAM read data
vpu_start  out  1  one-cycle start pulse to the vector unit
vpu_type  out  3  decoded type
opcode  out  10  scalar opcode
addr_a, addr_b, addr_out, addr_const  out  13 each  decoded addresses
vreg_dst, vreg_a, vreg_b, vpu_opcode  out  3 each  vector fields
scalar_b  out  1  scalar broadcast select
vpu_done  in  1  completion pulse from the vector unit

Behaviour:
- Instruction format, bits [63:61] = type:
  - 000 SCALAR: [60:51] opcode, [50:38] addr_a, [37:25] addr_b, [24:12] addr_out, [11:0] addr_const (zero-extended to 13 bits).
  - 001 VLOAD / 010 VSTORE / 011 VCOMPUTE: [60:58] vreg_dst, [57:55] vreg_a, [54:52] vreg_b, [51:49] vpu_opcode, [48] scalar_b, [47:35] addr_a. opcode, addr_b, addr_out and addr_const are driven 0.
  - 111 HALT.
  - 100, 101, 110 are illegal.
- Reset: all outputs 0, state IDLE, pc 0. Reset mid-program aborts immediately; vpu_start is never asserted in the cycle after reset.
- FSM states: IDLE, FETCH, FWAIT, DECODE, ISSUE, WAIT_DONE.
  - IDLE: on run, pc <= start_pc, clear halted/err/err_pc, busy <= 1, go to FETCH.
  - FETCH: imem_en = 1 and imem_addr = pc for exactly this cycle. Go to FWAIT, or to DECODE if IMEM_LAT = 1.
  - FWAIT: counter waits so that DECODE occurs IMEM_LAT cycles after FETCH.
  - DECODE: capture imem_dout.
    - Legal non-HALT type: register all fields, go to ISSUE.
    - HALT: busy <= 0, halted <= 1, go to IDLE.
    - Illegal type: busy <= 0, halted <= 1, err <= 1, err_pc <= pc, go to IDLE.
  - ISSUE: vpu_start = 1 for one cycle, go to WAIT_DONE.
  - WAIT_DONE: on vpu_done, pc <= pc + 1 (wraps to 0 at 2^PC_W - 1), go to FETCH. Otherwise stay; no timeout.
- All vpu field outputs, including vpu_type, are registered and stay constant from DECODE through the cycle vpu_done is seen. The vector unit muxes its done and BRAM signals on vpu_type, so this is required.
- Fields retain their last values while in IDLE.
- vpu_done outside WAIT_DONE is ignored.
- Minimum per-instruction overhead is IMEM_LAT + 3 cycles plus the vector unit's latency.
- run while busy is ignored. run in the same cycle as rst_n low is ignored.

Optional Feature:
- Macro VPU_ISSUE_PERF_EN. When defined, adds outputs perf_cycles (32 bit) and perf_instrs (32 bit):
  - Both cleared on an accepted run.
  - perf_cycles increments every cycle busy = 1.
  - perf_instrs increments on each vpu_done accepted in WAIT_DONE.
  - Both saturate at all-ones and hold after halt.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- VLOAD then HALT, IMEM_LAT=2: run with start_pc=0x010; imem[0x010] = type 001, vreg_dst=5, addr_a=0x0100; imem[0x011] = HALT; model vpu_done 12 cycles after start -> exactly one vpu_start; vpu_type=001, addr_a=0x0100, vreg_dst=5 stable until vpu_done; then halted=1, busy=0, err=0.
- Scalar decode: opcode=0x2A5, addr_a=0x1234, addr_b=0x0042, addr_out=0x1FFF, addr_const=0xABC -> outputs match, with addr_const=0x0ABC and vpu_type=000.
- Illegal type 101 at pc 0x020 -> no vpu_start; err=1, err_pc=0x020, halted=1; next run clears err.
- PC wrap: start_pc=0x3FF holds VCOMPUTE with scalar_b=1, imem[0x000]=HALT -> after vpu_done, imem_addr=0x000 and halt follows.
- Mid-program reset: assert rst_n=0 during WAIT_DONE -> next cycle busy=0 and all outputs 0; a late vpu_done after reset has no effect; a run pulsed while busy is ignored.
- VPU_ISSUE_PERF_EN with a 3-instruction program -> perf_instrs=3, and perf_cycles equals the counted busy cycles.
